// File: rtl/alu.sv
// Combinational ALU / shift / load-merge datapath with a registered {carry, zero, negative} flag snapshot.
// Define ALU_OVERFLOW_EN to add the signed-overflow output overflowOut for ADD/ADC/SUB/SBC.
module alu #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] operand1,
    input  logic [WIDTH-1:0] operand2,
    input  logic             carryIn,
    input  logic [2:0]       operation,
    input  logic             enableAlu,
    input  logic             enableShift,
    input  logic             enableLoad,
    output logic [WIDTH-1:0] result,
    output logic             carryOut,
    output logic             zeroOut,
    output logic             negativeOut,
`ifdef ALU_OVERFLOW_EN
    output logic             overflowOut,
`endif
    output logic [2:0]       flagsQ
);

    localparam int HALF = WIDTH / 2;

    logic [WIDTH-1:0] addend;
    logic             add_cin;
    logic [WIDTH:0]   sum;

    // One adder serves all four arithmetic ops; bit 1 selects subtraction.
    always_comb begin
        addend = operation[1] ? ~operand2 : operand2;
        unique case (operation[1:0])
            2'd0:    add_cin = 1'b0;
            2'd1:    add_cin = carryIn;
            2'd2:    add_cin = 1'b1;
            default: add_cin = carryIn;
        endcase
        sum = {1'b0, operand1} + {1'b0, addend} + {{WIDTH{1'b0}}, add_cin};
    end

    always_comb begin
        result   = '0;
        carryOut = carryIn;
        if (enableAlu) begin
            unique case (operation)
                3'd0, 3'd1, 3'd2, 3'd3: begin
                    result   = sum[WIDTH-1:0];
                    carryOut = sum[WIDTH];
                end
                3'd4:    result = operand1 & operand2;
                3'd5:    result = operand1 | operand2;
                3'd6:    result = operand1 ^ operand2;
                default: result = ~operand1;
            endcase
        end else if (enableShift) begin
            unique case (operation)
                3'd0: begin
                    result   = {1'b0, operand1[WIDTH-1:1]};
                    carryOut = operand1[0];
                end
                3'd1: begin
                    result   = {operand1[WIDTH-2:0], 1'b0};
                    carryOut = operand1[WIDTH-1];
                end
                3'd2: begin
                    result   = {operand1[WIDTH-1], operand1[WIDTH-1:1]};
                    carryOut = operand1[0];
                end
                3'd3: begin
                    result   = {carryIn, operand1[WIDTH-1:1]};
                    carryOut = operand1[0];
                end
                3'd4: begin
                    result   = {operand1[WIDTH-2:0], carryIn};
                    carryOut = operand1[WIDTH-1];
                end
                default: result = operand1;
            endcase
        end else if (enableLoad) begin
            unique case (operation)
                3'd0:       result = operand1;
                3'd1, 3'd4: result = {operand2[WIDTH-1:HALF], operand1[HALF-1:0]};
                3'd2, 3'd5: result = {operand1[HALF-1:0], operand2[HALF-1:0]};
                3'd3:       result = {operand1[HALF-1:0], operand1[WIDTH-1:HALF]};
                3'd6:       result = {{(WIDTH-HALF){1'b0}}, operand1[HALF-1:0]};
                default:    result = {operand1[HALF-1:0], {HALF{1'b0}}};
            endcase
        end
    end

    assign zeroOut     = (result == '0);
    assign negativeOut = result[WIDTH-1];

`ifdef ALU_OVERFLOW_EN
    // Overflow when both addends share a sign the sum does not; addend is already ~op2 for SUB/SBC.
    assign overflowOut = enableAlu && !operation[2] &&
                         (operand1[WIDTH-1] == addend[WIDTH-1]) &&
                         (sum[WIDTH-1] != operand1[WIDTH-1]);
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            flagsQ <= 3'b000;
        else if (enableAlu || enableShift || enableLoad)
            flagsQ <= {carryOut, zeroOut, negativeOut};
    end

endmodule

// File: tb/tb_alu.sv
// Directed-vector bench for alu: hand-computed results, carries, priority and flag-register behaviour.
module tb_alu;
    logic        clk;
    logic        reset;
    logic [15:0] operand1;
    logic [15:0] operand2;
    logic        carryIn;
    logic [2:0]  operation;
    logic        enableAlu;
    logic        enableShift;
    logic        enableLoad;
    logic [15:0] result;
    logic        carryOut;
    logic        zeroOut;
    logic        negativeOut;
    logic [2:0]  flagsQ;
`ifdef ALU_OVERFLOW_EN
    logic        overflowOut;
`endif

    int tests_run = 0;
    int tests_failed = 0;

    alu #(.WIDTH(16)) dut (
        .clk(clk),
        .reset(reset),
        .operand1(operand1),
        .operand2(operand2),
        .carryIn(carryIn),
        .operation(operation),
        .enableAlu(enableAlu),
        .enableShift(enableShift),
        .enableLoad(enableLoad),
        .result(result),
        .carryOut(carryOut),
        .zeroOut(zeroOut),
        .negativeOut(negativeOut),
`ifdef ALU_OVERFLOW_EN
        .overflowOut(overflowOut),
`endif
        .flagsQ(flagsQ)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // en = {alu, shift, load}
    task automatic drive(input logic [2:0] en, input logic [2:0] op,
                         input logic [15:0] a, input logic [15:0] b, input logic cin);
        {enableAlu, enableShift, enableLoad} = en;
        operation = op;
        operand1  = a;
        operand2  = b;
        carryIn   = cin;
        #1;
    endtask

    task automatic vec(input string tag, input logic [2:0] en, input logic [2:0] op,
                       input logic [15:0] a, input logic [15:0] b, input logic cin,
                       input logic [15:0] exp_res, input logic exp_c);
        drive(en, op, a, b, cin);
        check({tag, ".result"}, {16'h0, result}, {16'h0, exp_res});
        check({tag, ".carry"}, {31'h0, carryOut}, {31'h0, exp_c});
        check({tag, ".zero"}, {31'h0, zeroOut}, {31'h0, (exp_res == 16'h0)});
        check({tag, ".neg"}, {31'h0, negativeOut}, {31'h0, exp_res[15]});
    endtask

    initial begin
        reset = 1'b0;
        drive(3'b000, 3'd0, 16'h0, 16'h0, 1'b0);
        #3;
        check("reset_flags", {29'h0, flagsQ}, 32'h0);
        // combinational path works while in reset
        vec("add_in_reset", 3'b100, 3'd0, 16'h0001, 16'h0002, 1'b0, 16'h0003, 1'b0);
        @(negedge clk);
        check("reset_holds_flags", {29'h0, flagsQ}, 32'h0);
        reset = 1'b1;

        // arithmetic
        vec("add_wrap", 3'b100, 3'd0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1);
        vec("add_ign_cin", 3'b100, 3'd0, 16'h0001, 16'h0001, 1'b1, 16'h0002, 1'b0);
        vec("adc", 3'b100, 3'd1, 16'h0001, 16'h0001, 1'b1, 16'h0003, 1'b0);
        vec("sub_borrow", 3'b100, 3'd2, 16'h0003, 16'h0005, 1'b0, 16'hFFFE, 1'b0);
        vec("sub_noborrow", 3'b100, 3'd2, 16'h0005, 16'h0003, 1'b0, 16'h0002, 1'b1);
        vec("sbc_cin0", 3'b100, 3'd3, 16'h0005, 16'h0003, 1'b0, 16'h0001, 1'b1);
        vec("sbc_cin1", 3'b100, 3'd3, 16'h0005, 16'h0003, 1'b1, 16'h0002, 1'b1);
        // logic
        vec("and", 3'b100, 3'd4, 16'hF0F0, 16'hFF00, 1'b1, 16'hF000, 1'b1);
        vec("or", 3'b100, 3'd5, 16'hF0F0, 16'hFF00, 1'b0, 16'hFFF0, 1'b0);
        vec("xor", 3'b100, 3'd6, 16'hF0F0, 16'hFF00, 1'b1, 16'h0FF0, 1'b1);
        vec("not", 3'b100, 3'd7, 16'hF0F0, 16'hFF00, 1'b0, 16'h0F0F, 1'b0);
        // shifts
        vec("shr", 3'b010, 3'd0, 16'h8001, 16'h0, 1'b1, 16'h4000, 1'b1);
        vec("shl", 3'b010, 3'd1, 16'h8001, 16'h0, 1'b0, 16'h0002, 1'b1);
        vec("ashr", 3'b010, 3'd2, 16'h8001, 16'h0, 1'b1, 16'hC000, 1'b1);
        vec("ror", 3'b010, 3'd3, 16'h8001, 16'h0, 1'b1, 16'hC000, 1'b1);
        vec("rol", 3'b010, 3'd4, 16'h8001, 16'h0, 1'b1, 16'h0003, 1'b1);
        vec("ror_c0", 3'b010, 3'd3, 16'h0002, 16'h0, 1'b0, 16'h0001, 1'b0);
        vec("shift_pass5", 3'b010, 3'd5, 16'h8001, 16'h0, 1'b0, 16'h8001, 1'b0);
        vec("shift_pass7", 3'b010, 3'd7, 16'h1234, 16'h0, 1'b1, 16'h1234, 1'b1);
        // loads
        vec("ld", 3'b001, 3'd0, 16'h12AB, 16'h3456, 1'b0, 16'h12AB, 1'b0);
        vec("ldl", 3'b001, 3'd1, 16'h12AB, 16'h3456, 1'b1, 16'h34AB, 1'b1);
        vec("ldh", 3'b001, 3'd2, 16'h12AB, 16'h3456, 1'b0, 16'hAB56, 1'b0);
        vec("swp", 3'b001, 3'd3, 16'h12AB, 16'h3456, 1'b1, 16'hAB12, 1'b1);
        vec("ldl_imm", 3'b001, 3'd4, 16'h12AB, 16'h3456, 1'b0, 16'h34AB, 1'b0);
        vec("ldh_imm", 3'b001, 3'd5, 16'h12AB, 16'h3456, 1'b1, 16'hAB56, 1'b1);
        vec("ldlz", 3'b001, 3'd6, 16'h12AB, 16'h3456, 1'b0, 16'h00AB, 1'b0);
        vec("ldhz", 3'b001, 3'd7, 16'h12AB, 16'h3456, 1'b1, 16'hAB00, 1'b1);
        // priority
        vec("prio_all", 3'b111, 3'd0, 16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0);
        vec("prio_shift_load", 3'b011, 3'd0, 16'h8001, 16'h0001, 1'b0, 16'h4000, 1'b1);
        vec("none_c1", 3'b000, 3'd0, 16'h1234, 16'h5678, 1'b1, 16'h0000, 1'b1);
        vec("none_c0", 3'b000, 3'd3, 16'h1234, 16'h5678, 1'b0, 16'h0000, 1'b0);

`ifdef ALU_OVERFLOW_EN
        drive(3'b100, 3'd0, 16'h7FFF, 16'h0001, 1'b0);
        check("ovf_add", {31'h0, overflowOut}, 32'h1);
        drive(3'b100, 3'd0, 16'hFFFF, 16'h0001, 1'b0);
        check("ovf_add_none", {31'h0, overflowOut}, 32'h0);
        drive(3'b100, 3'd2, 16'h8000, 16'h0001, 1'b0);
        check("ovf_sub", {31'h0, overflowOut}, 32'h1);
        drive(3'b010, 3'd0, 16'h7FFF, 16'h0001, 1'b0);
        check("ovf_shift_zero", {31'h0, overflowOut}, 32'h0);
`endif

        // flag register: capture, hold, async clear, recapture
        @(negedge clk);
        drive(3'b100, 3'd0, 16'hFFFF, 16'h0001, 1'b0);
        @(negedge clk);
        check("flags_capture", {29'h0, flagsQ}, 32'h6);
        drive(3'b000, 3'd0, 16'h8000, 16'h0000, 1'b0);
        @(negedge clk);
        check("flags_hold", {29'h0, flagsQ}, 32'h6);
        #2;
        reset = 1'b0;
        #1;
        check("flags_async_clear", {29'h0, flagsQ}, 32'h0);
        @(negedge clk);
        check("flags_clear_held", {29'h0, flagsQ}, 32'h0);
        reset = 1'b1;
        drive(3'b100, 3'd2, 16'h0003, 16'h0005, 1'b0);
        @(negedge clk);
        check("flags_after_reset", {29'h0, flagsQ}, 32'h1);
        drive(3'b001, 3'd6, 16'h1200, 16'h0000, 1'b1);
        @(negedge clk);
        check("flags_load", {29'h0, flagsQ}, 32'h6);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
